set_pattern_host: RTL and testbench
===================================

Name: set_pattern_host

Overview:
- Synthesizable initiator for the SET candidate-counting engine's en/busy/valid interface.
- Reads circle patterns and expected counts from a synchronous pattern ROM, issues each pattern to SET and captures `candidate`.
- Compares each response against the expected value and reports pass/fail plus an error count.
- Used for on-chip self-test and emulation, where no simulation bench drives SET.

Parameters:
- NUM_PAT, 64: number of patterns per run (ROM depth).
- IDX_W, 6: pattern address width, ceil(log2(NUM_PAT)).
- ERR_LIMIT, 10: error count at which the run aborts.
- TIMEOUT_CYC, 4096: watchdog limit in cycles; used only with SET_HOST_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- mode_sel  in  2  SET mode for the run; latched on an accepted start.
- pat_addr  out  IDX_W  ROM address; ROM has 1-cycle read latency.
- pat_central  in  24  ROM data: central coordinates.
- pat_radius  in  12  ROM data: radii.
- pat_expected  in  8  ROM data: expected candidate count.
- set_en  out  1  to SET en.
- set_central  out  24  to SET central.
- set_radius  out  12  to SET radius.
- set_mode  out  2  to SET mode.
- set_busy  in  1  from SET busy.
- set_valid  in  1  from SET valid.
- set_candidate  in  8  from SET candidate.
- done  out  1  run finished; held high until the next accepted start.
- pass  out  1  qualified by done; 1 means err_cnt == 0.
- abort  out  1  qualified by done; run stopped at ERR_LIMIT (or on timeout).
- err_cnt  out  7  mismatches in the current run, saturating at 127.

Behaviour:
- Reset (synchronous, rst=1 on a clock edge):
  - state=IDLE, idx=0.
  - Outputs zero: set_en, set_central, set_radius, set_mode, done, pass, abort, err_cnt, pat_addr.
  - Reset overrides every state, including mid-transaction. set_en is 0 in the cycle after rst is sampled.
- States: IDLE, FETCH, LOAD, WAIT_IDLE, ISSUE, WAIT_VALID, CHECK, DONE.
- IDLE/DONE + start=1 → FETCH:
  - Latch mode_sel into set_mode.
  - Clear idx, err_cnt, done, pass and abort.
  - Any other state ignores start.
- pat_addr = idx (registered).
- FETCH → LOAD, unconditional.
- LOAD: capture pat_central → set_central, pat_radius → set_radius, pat_expected → exp_r; → WAIT_IDLE.
- WAIT_IDLE: stay while set_busy=1; when set_busy=0 → ISSUE.
- ISSUE:
  - set_en=1 for exactly this one cycle.
  - set_central and set_radius are stable from LOAD through end of ISSUE.
  - → WAIT_VALID.
- WAIT_VALID:
  - set_valid is sampled starting the cycle after ISSUE; a valid coincident with ISSUE is ignored.
  - On set_valid=1: register set_candidate != exp_r as the mismatch flag; → CHECK.
  - set_valid outside WAIT_VALID is ignored.
- CHECK:
  - On mismatch, err_cnt += 1, saturating.
  - If the new err_cnt == ERR_LIMIT → DONE with abort=1.
  - Else if idx == NUM_PAT-1 → DONE.
  - Else idx += 1 and → FETCH.
  - idx never wraps within a run.
- DONE:
  - done=1 and pass = (err_cnt == 0).
  - set_mode holds its value.
  - Outputs hold until the next start or reset.
- Per-pattern minimum latency: 5 cycles plus SET processing time.
- set_mode is constant for the whole run and never changes while SET is busy.

Optional Feature:
- Macro: SET_HOST_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_IDLE and to WAIT_VALID, and increments each cycle in those states.
  - On reaching TIMEOUT_CYC: err_cnt += 1, abort=1, → DONE.
- Not defined:
  - No counter logic is built.
  - WAIT_IDLE and WAIT_VALID wait indefinitely.

Test Plan:
- Reset then idle: rst high 3 cycles → all outputs 0, state IDLE, start pulses during rst ignored.
- Full pass, mode_sel=2'b01:
  - Model SET returns pat_expected 3 cycles after en.
  - → 64 en pulses, each 1 cycle wide; set_mode=01 throughout.
  - → done=1, pass=1, err_cnt=0, abort=0.
- Busy handshake: hold set_busy=1 for 20 cycles after LOAD → set_en stays 0; set_en pulses exactly 1 cycle after set_busy falls.
- Mismatches: model returns expected+1 on patterns 5 and 40 → done=1, pass=0, err_cnt=2, abort=0.
- Abort: model always wrong → abort after pattern idx 9; done=1, err_cnt=10, exactly 10 en pulses issued.
- Reset mid-run plus timeout:
  - rst asserted in WAIT_VALID of pattern 7 → IDLE next cycle; a new start re-runs from pat_addr=0 with err_cnt=0.
  - With SET_HOST_TIMEOUT_EN and set_valid never asserting → done=1, abort=1, err_cnt=1 after TIMEOUT_CYC cycles.

Source files
------------

// File: rtl/set_pattern_host.sv
// set_pattern_host: self-test initiator for the SET candidate-counting engine.
// Walks a synchronous pattern ROM, issues each pattern to SET over its
// en/busy/valid handshake and compares every candidate against the expected
// count. It reports done/pass/abort and a saturating error count.
// Optional feature: define SET_HOST_TIMEOUT_EN to build a watchdog on the two
// wait states. Without it the host waits indefinitely for SET.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | after reset, waiting for start
// FETCH       | ROM address presented, data arrives next cycle
// LOAD        | capture ROM data into the SET operand and expected registers
// WAIT_IDLE   | hold off while SET reports busy
// ISSUE       | single-cycle set_en pulse
// WAIT_VALID  | wait for SET result
// CHECK       | update error count, pick the next pattern or finish
// DONE        | results held until the next start

module set_pattern_host #(
    parameter int NUM_PAT     = 64,
    parameter int IDX_W       = 6,
    parameter int ERR_LIMIT   = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode_sel,
    output logic [IDX_W-1:0] pat_addr,
    input  logic [23:0]      pat_central,
    input  logic [11:0]      pat_radius,
    input  logic [7:0]       pat_expected,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             done,
    output logic             pass,
    output logic             abort,
    output logic [6:0]       err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_WAIT_IDLE, S_ISSUE, S_WAIT_VALID, S_CHECK, S_DONE
    } state_t;

    localparam logic [6:0]       ERR_LIM  = 7'(ERR_LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       exp_r;
    logic             mismatch;
    logic [6:0]       err_inc;
    logic [6:0]       err_new;
    logic             timeout;

    assign pat_addr = idx;
    assign err_inc  = (err_cnt == 7'd127) ? err_cnt : err_cnt + 7'd1;
    assign err_new  = mismatch ? err_inc : err_cnt;

`ifdef SET_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog: LOAD and ISSUE always lead into a wait state, so clearing there
    // restarts the count on every entry to WAIT_IDLE and WAIT_VALID.
    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state == S_LOAD || state == S_ISSUE)
            wd_cnt <= '0;
        else if (state == S_WAIT_IDLE || state == S_WAIT_VALID)
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    // Fires on the TIMEOUT_CYC-th cycle in a wait state; a real handshake wins.
    assign timeout = ((state == S_WAIT_IDLE && set_busy) ||
                      (state == S_WAIT_VALID && !set_valid)) &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and the set_en strobe.
    always_comb begin
        state_nxt = state;
        set_en    = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_LOAD;
            S_LOAD:         state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (!set_busy)    state_nxt = S_ISSUE;
                else if (timeout) state_nxt = S_DONE;
            end
            S_ISSUE: begin
                set_en    = 1'b1;
                state_nxt = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                if (set_valid)    state_nxt = S_CHECK;
                else if (timeout) state_nxt = S_DONE;
            end
            S_CHECK: begin
                if (err_new == ERR_LIM || idx == LAST_IDX) state_nxt = S_DONE;
                else                                       state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operands, run status and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            exp_r       <= '0;
            mismatch    <= 1'b0;
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            abort       <= 1'b0;
            err_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        set_mode <= mode_sel;
                        idx      <= '0;
                        err_cnt  <= '0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        abort    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    set_central <= pat_central;
                    set_radius  <= pat_radius;
                    exp_r       <= pat_expected;
                end
                S_WAIT_IDLE, S_WAIT_VALID: begin
                    if (state == S_WAIT_VALID && set_valid) begin
                        mismatch <= (set_candidate != exp_r);
                    end else if (timeout) begin
                        err_cnt <= err_inc;
                        abort   <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    err_cnt <= err_new;
                    if (err_new == ERR_LIM) begin
                        done  <= 1'b1;
                        abort <= 1'b1;
                        pass  <= 1'b0;
                    end else if (idx == LAST_IDX) begin
                        done <= 1'b1;
                        pass <= (err_new == 7'd0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_set_pattern_host.sv
// tb_set_pattern_host: directed self-checking bench for set_pattern_host.
// A behavioural SET model answers each en with a configurable candidate and
// latency. A scoreboard queue holds the operands expected at each set_en.
module tb_set_pattern_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode_sel = 2'b00;
    logic [5:0]  pat_addr;
    logic [23:0] pat_central;
    logic [11:0] pat_radius;
    logic [7:0]  pat_expected;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid = 1'b0;
    logic [7:0]  set_candidate = 8'h00;
    logic        done, pass, abort;
    logic [6:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    set_pattern_host dut (
        .clk(clk), .rst(rst), .start(start), .mode_sel(mode_sel),
        .pat_addr(pat_addr), .pat_central(pat_central), .pat_radius(pat_radius),
        .pat_expected(pat_expected), .set_en(set_en), .set_central(set_central),
        .set_radius(set_radius), .set_mode(set_mode), .set_busy(set_busy),
        .set_valid(set_valid), .set_candidate(set_candidate), .done(done),
        .pass(pass), .abort(abort), .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern ROM: the low 6 bits of central carry the pattern index.
    logic [23:0] rom_c [64];
    logic [11:0] rom_r [64];
    logic [7:0]  rom_e [64];

    always @(posedge clk) begin
        pat_central  <= rom_c[pat_addr];
        pat_radius   <= rom_r[pat_addr];
        pat_expected <= rom_e[pat_addr];
    end

    // SET model: wrong_mode 0 = always right, 1 = wrong on 5 and 40, 2 = always wrong.
    int         lat = 3;
    int         wrong_mode = 0;
    bit         never_valid = 1'b0;
    bit         force_busy = 1'b0;
    logic       model_busy = 1'b0;
    int         mcnt = 0;
    logic [7:0] mcand = 8'h00;

    assign set_busy = model_busy | force_busy;

    function automatic logic [7:0] model_resp(input logic [5:0] i);
        logic [7:0] e;
        e = rom_e[i];
        if (wrong_mode == 2 || (wrong_mode == 1 && (i == 6'd5 || i == 6'd40)))
            e = e + 8'd1;
        return e;
    endfunction

    always @(negedge clk) begin
        set_valid = 1'b0;
        if (rst) begin
            model_busy = 1'b0;
            mcnt = 0;
        end else if (set_en) begin
            model_busy = 1'b1;
            mcnt  = lat;
            mcand = model_resp(set_central[5:0]);
        end else if (model_busy && !never_valid) begin
            if (mcnt <= 1) begin
                set_valid     = 1'b1;
                set_candidate = mcand;
                model_busy    = 1'b0;
            end else begin
                mcnt = mcnt - 1;
            end
        end
    end

    // Scoreboard of operands expected at each set_en, in ROM order.
    typedef struct packed {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
    } txn_t;
    txn_t sb[$];
    int   en_cnt = 0;
    logic en_prev = 1'b0;

    task automatic push_run(input logic [1:0] m);
        sb.delete();
        for (int i = 0; i < 64; i++) sb.push_back({rom_c[i], rom_r[i], m});
    endtask

    always @(negedge clk) begin
        txn_t t;
        if (set_en) begin
            en_cnt++;
            chk("en_width", 32'(en_prev), 32'd0);
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                t = sb.pop_front();
                chk("en_central", 32'(set_central), 32'(t.c));
                chk("en_radius", 32'(set_radius), 32'(t.r));
                chk("en_mode", 32'(set_mode), 32'(t.m));
            end
        end
        en_prev = set_en;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        @(negedge clk);
        mode_sel = m;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mode_sel = ~m;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    task automatic expect_end(input string tag, input logic p, input logic a,
                              input int e, input int ens);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), 32'(p));
        chk({tag, "_abort"}, 32'(abort), 32'(a));
        chk({tag, "_err"}, 32'(err_cnt), 32'(e));
        chk({tag, "_en_cnt"}, 32'(en_cnt), 32'(ens));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            rom_c[i] = {8'(i * 37), 10'(i * 113 + 5), 6'(i)};
            rom_r[i] = 12'(i * 29 + 1);
            rom_e[i] = 8'(i * 13 + 7);
        end

        // Reset with start pulses ignored.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = i[0];
        end
        @(posedge clk);
        #1;
        chk("rst_en", 32'(set_en), 32'd0);
        chk("rst_central", 32'(set_central), 32'd0);
        chk("rst_radius", 32'(set_radius), 32'd0);
        chk("rst_mode", 32'(set_mode), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_addr", 32'(pat_addr), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        cyc(4);
        chk("idle_en", 32'(set_en), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_addr", 32'(pat_addr), 32'd0);

        // Full passing run, mode 01.
        push_run(2'b01);
        en_cnt = 0;
        do_start(2'b01);
        wait_done(2000);
        expect_end("full", 1'b1, 1'b0, 0, 64);
        chk("full_mode_held", 32'(set_mode), 32'd1);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);

        // Busy handshake: SET busy for 20+ cycles before the first issue.
        @(negedge clk);
        force_busy = 1'b1;
        push_run(2'b00);
        en_cnt = 0;
        do_start(2'b00);
        cyc(22);
        chk("busy_no_en", 32'(en_cnt), 32'd0);
        @(negedge clk);
        force_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_en_rise", 32'(set_en), 32'd1);
        @(posedge clk);
        #1;
        chk("busy_en_fall", 32'(set_en), 32'd0);
        wait_done(2000);
        expect_end("busy", 1'b1, 1'b0, 0, 64);

        // Mismatches on patterns 5 and 40.
        wrong_mode = 1;
        push_run(2'b10);
        en_cnt = 0;
        do_start(2'b10);
        wait_done(2000);
        expect_end("mism", 1'b0, 1'b0, 2, 64);
        chk("mism_mode_held", 32'(set_mode), 32'd2);

        // Every answer wrong: abort at the error limit after pattern 9.
        wrong_mode = 2;
        push_run(2'b11);
        en_cnt = 0;
        do_start(2'b11);
        wait_done(2000);
        expect_end("abort", 1'b0, 1'b1, 10, 10);
        chk("abort_sb_left", 32'(sb.size()), 32'd54);
        chk("abort_addr", 32'(pat_addr), 32'd9);

        // Reset while waiting on pattern 7, then a clean rerun.
        wrong_mode = 1;
        push_run(2'b01);
        en_cnt = 0;
        do_start(2'b01);
        n = 0;
        while (!(set_en && set_central[5:0] == 6'd7) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mid_reached_p7", 32'(set_en), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_err_before", 32'(err_cnt), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_en", 32'(set_en), 32'd0);
        chk("mid_rst_addr", 32'(pat_addr), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        cyc(1);
        @(negedge clk);
        rst = 1'b0;
        wrong_mode = 0;
        push_run(2'b01);
        en_cnt = 0;
        do_start(2'b01);
        chk("rerun_addr", 32'(pat_addr), 32'd0);
        chk("rerun_err", 32'(err_cnt), 32'd0);
        wait_done(2000);
        expect_end("rerun", 1'b1, 1'b0, 0, 64);

`ifdef SET_HOST_TIMEOUT_EN
        // SET never answers: watchdog ends the run.
        never_valid = 1'b1;
        push_run(2'b00);
        en_cnt = 0;
        do_start(2'b00);
        wait_done(6000);
        expect_end("tmo", 1'b0, 1'b1, 1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
